data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DATA_W, default 32: data word width.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter DEPTH, default 256: number of words in the array, power of two.
REQ-004 Parameter WAIT_CYCLES, default 2: access latency in cycles, minimum 1.
REQ-005 clk  in  1  clock; all state updates on posedge clk.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 req_valid  in  1  MEM-stage access request.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  ADDR_W  byte address (ALUOutM).
REQ-010 req_wdata  in  DATA_W  store data.
REQ-011 req_ready  out  1  responder can accept a request this cycle.
REQ-012 resp_valid  out  1  one-cycle completion pulse.
REQ-013 resp_rdata  out  DATA_W  load data (DMOutM), valid only with resp_valid.
REQ-014 resp_err  out  1  misaligned access, valid only with resp_valid.
REQ-015 stall  out  1  freeze IF/ID/EX/MEM pipeline registers.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT, RESP.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 The block SHALL accept a request on a posedge with req_valid=1 in IDLE, latching req_we, req_addr and req_wdata.
REQ-019 After acceptance the FSM SHALL go to WAIT if WAIT_CYCLES>1, else directly to RESP.
REQ-020 WAIT SHALL last WAIT_CYCLES-1 cycles, counted by a down-counter, then go to RESP.
REQ-021 resp_valid SHALL be 1 for exactly the one cycle spent in RESP, which is WAIT_CYCLES cycles after the accepting edge; RESP SHALL always return to IDLE.
REQ-022 stall SHALL be 1 in IDLE when req_valid=1, and throughout WAIT; it SHALL be 0 in RESP.
REQ-023 Word index SHALL be the latched address bits [log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so out-of-range addresses alias.
REQ-024 A store SHALL commit to the array on the edge entering RESP; in RESP, resp_rdata SHALL be 0.
REQ-025 A load SHALL present the array word at the latched index on resp_rdata during RESP.
REQ-026 If the latched address bits [1:0] are nonzero, then resp_err SHALL be 1 and resp_rdata SHALL be 0, and a store SHALL NOT write.
REQ-027 A request presented during WAIT or RESP SHALL be ignored; the MEM stage holds it, since stall keeps it stable.
REQ-028 A load immediately after a store to the same word SHALL return the stored data.
REQ-029 In IDLE and WAIT, resp_rdata SHALL be 0 and resp_err SHALL be 0.

Reset
REQ-030 rst SHALL force IDLE, counter 0, resp_valid 0, resp_err 0, resp_rdata 0 and stall 0, while req_ready becomes 1.
REQ-031 rst during WAIT SHALL abort the access with no array write and no response.
REQ-032 rst SHALL NOT clear array contents.
REQ-033 rst SHALL take priority over every other event in the same cycle.

Structure
REQ-034 The FSM state enum and default parameter constants SHALL live in the shared package mem_pkg.
REQ-035 Storage SHALL be a sub-module dmem_array: single-port, synchronous write, DEPTH x DATA_W.
REQ-036 The counter width SHALL be $clog2(WAIT_CYCLES)+1.

Verification
REQ-037 Reset, then store 0xDEADBEEF to 0x10 with WAIT_CYCLES=2 -> stall=1 for 2 cycles, then resp_valid for 1 cycle with resp_err=0.
REQ-038 Load 0x10 immediately after that store -> resp_valid exactly 2 cycles after acceptance, with resp_rdata=0xDEADBEEF.
REQ-039 Store to 0x13 -> resp_err=1; a following load of 0x10 still returns 0xDEADBEEF.
REQ-040 Load 0x410 with DEPTH=256 -> aliases word 4, returning 0xDEADBEEF.
REQ-041 Assert rst mid-WAIT of a store of 0x12345678 to 0x20 -> no response, req_ready=1 next cycle, a later load of 0x20 returns the prior value.
REQ-042 Hold req_valid=1 continuously with WAIT_CYCLES=1 -> one acceptance every 2 cycles, with resp_valid alternating 0/1.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the MEM-stage data memory responder: default
// parameters, FSM state encoding and a small alignment helper.
package mem_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 32;
    localparam int DEPTH_DEF       = 256;
    localparam int WAIT_CYCLES_DEF = 2;

    // Responder FSM states, kept as plain constants so legacy code that
    // compares raw 2-bit state values keeps working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, combinational read on the
// same index. Contents are never reset.
module dmem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Commit a word on the clock edge when write is enabled.
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: accepts one load/store in IDLE, holds
// the pipeline for WAIT_CYCLES, then pulses a one-cycle response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(WAIT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;

    logic              lat_we;
    logic              lat_mis;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;

    logic              accept;
    logic              enter_resp;
    logic              src_we;
    logic              src_mis;
    logic [IDX_W-1:0]  src_idx;
    logic [DATA_W-1:0] src_wdata;
    logic              arr_we;
    logic [DATA_W-1:0] arr_rdata;

    // Upper address bits only select aliases of the same word.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

    assign accept     = (state == ST_IDLE) && req_valid;
    assign enter_resp = (accept && (WAIT_CYCLES == 1)) ||
                        ((state == ST_WAIT) && (cnt == CNT_ONE));

    // With a single-cycle latency the store commits on the accepting edge,
    // before anything is latched, so the array sees the live request then.
    always_comb begin
        src_we    = lat_we;
        src_mis   = lat_mis;
        src_idx   = lat_idx;
        src_wdata = lat_wdata;
        if (state == ST_IDLE) begin
            src_we    = req_we;
            src_mis   = misaligned(req_addr[1:0]);
            src_idx   = req_addr[IDX_W+1:2];
            src_wdata = req_wdata;
        end
    end

    // Aligned stores only; reset in the same cycle cancels the write.
    assign arr_we = !rst && enter_resp && src_we && !src_mis;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .idx   (src_idx),
        .wdata (src_wdata),
        .rdata (arr_rdata)
    );

    // FSM and latency down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (WAIT_CYCLES > 1) begin
                            state <= ST_WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ST_RESP;
                            cnt   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == CNT_ONE) begin
                        state <= ST_RESP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Capture the request on acceptance; the MEM stage is frozen afterwards.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            lat_we    <= req_we;
            lat_mis   <= misaligned(req_addr[1:0]);
            lat_idx   <= req_addr[IDX_W+1:2];
            lat_wdata <= req_wdata;
        end
    end

    // Outputs decoded from state; data and error are zero outside RESP.
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && lat_mis;
        resp_rdata = '0;
        if ((state == ST_RESP) && !lat_we && !lat_mis) resp_rdata = arr_rdata;
        stall = !rst && (((state == ST_IDLE) && req_valid) || (state == ST_WAIT));
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench: a WAIT_CYCLES=2 responder checked against
// an array model, plus a WAIT_CYCLES=1 responder under back-to-back requests.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_valid = 1'b0, a_we = 1'b0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic        a_ready, a_resp, a_err, a_stall;
    logic [31:0] a_rdata;

    logic        b_valid = 1'b0, b_we = 1'b0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic        b_ready, b_resp, b_err, b_stall;
    logic [31:0] b_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mdl [DEPTH];
    bit          mvalid [DEPTH];

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(LAT_A)) dut_a (
        .clk(clk), .rst(rst), .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr),
        .req_wdata(a_wdata), .req_ready(a_ready), .resp_valid(a_resp),
        .resp_rdata(a_rdata), .resp_err(a_err), .stall(a_stall));

    data_mem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr),
        .req_wdata(b_wdata), .req_ready(b_ready), .resp_valid(b_resp),
        .resp_rdata(b_rdata), .resp_err(b_err), .stall(b_stall));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_a(input int n);
        a_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // One access on responder A; called at a negedge. Leaves the request
    // held during the response cycle, as a frozen MEM stage would.
    task automatic access_a(input bit we, input logic [31:0] addr, input logic [31:0] wd);
        int  idx;
        bit  mis;
        a_valid = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        if (!a_ready) step();
        #1;
        check("ready_idle", {31'b0, a_ready}, 32'd1);
        check("stall_req", {31'b0, a_stall}, 32'd1);
        idx = int'((addr >> 2) % DEPTH);
        mis = (addr % 4) != 0;
        for (int k = 1; k <= LAT_A; k++) begin
            step();
            if (k < LAT_A) begin
                check("wait_resp", {31'b0, a_resp}, 32'd0);
                check("wait_stall", {31'b0, a_stall}, 32'd1);
                check("wait_ready", {31'b0, a_ready}, 32'd0);
                check("wait_rdata", a_rdata, 32'd0);
            end else begin
                check("resp_valid", {31'b0, a_resp}, 32'd1);
                check("resp_stall", {31'b0, a_stall}, 32'd0);
                check("resp_err", {31'b0, a_err}, {31'b0, mis});
                if (we || mis)          check("resp_rdata0", a_rdata, 32'd0);
                else if (mvalid[idx])   check("resp_rdata", a_rdata, mdl[idx]);
                if (we && !mis) begin
                    mdl[idx]    = wd;
                    mvalid[idx] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;

        // Reset state, sampled with reset still asserted and after release.
        repeat (3) step();
        check("rst_ready", {31'b0, a_ready}, 32'd1);
        check("rst_resp", {31'b0, a_resp}, 32'd0);
        check("rst_stall", {31'b0, a_stall}, 32'd0);
        check("rst_rdata", a_rdata, 32'd0);
        check("rst_err", {31'b0, a_err}, 32'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", {31'b0, a_ready}, 32'd1);

        // Directed scenarios.
        access_a(1'b1, 32'h10, 32'hDEADBEEF);
        access_a(1'b0, 32'h10, 32'h0);
        access_a(1'b1, 32'h13, 32'h55555555);
        access_a(1'b0, 32'h10, 32'h0);
        check("after_mis_store", a_rdata, 32'hDEADBEEF);
        access_a(1'b0, 32'h410, 32'h0);
        check("alias_410", a_rdata, 32'hDEADBEEF);

        // Reset in the middle of a store's wait period.
        access_a(1'b1, 32'h20, 32'hCAFEF00D);
        idle_a(1);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'h12345678;
        step();
        check("abort_in_wait", {31'b0, a_stall}, 32'd1);
        rst = 1'b1; a_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("abort_ready", {31'b0, a_ready}, 32'd1);
        check("abort_resp", {31'b0, a_resp}, 32'd0);
        check("abort_stall", {31'b0, a_stall}, 32'd0);
        step();
        check("abort_no_resp", {31'b0, a_resp}, 32'd0);
        access_a(1'b0, 32'h20, 32'h0);
        check("abort_kept", a_rdata, 32'hCAFEF00D);

        // Random traffic over a small word window with aliasing and misalignment.
        for (int n = 0; n < 80; n++) begin
            logic [31:0] addr;
            addr = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 10);
            if ($urandom_range(0, 3) == 0) addr = addr | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) idle_a($urandom_range(1, 2));
            access_a(1'($urandom_range(0, 1)), addr, $urandom);
        end
        idle_a(2);

        // Single-cycle latency with the request held: accept every other cycle.
        b_valid = 1'b1; b_we = 1'b1; b_addr = 32'h8; b_wdata = 32'h0BADCAFE;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c % 2 == 1) begin
                check("b_resp_on", {31'b0, b_resp}, 32'd1);
                check("b_stall_resp", {31'b0, b_stall}, 32'd0);
                check("b_rdata", b_rdata, (c == 1) ? 32'd0 : 32'h0BADCAFE);
                b_we = 1'b0;
            end else begin
                check("b_resp_off", {31'b0, b_resp}, 32'd0);
                check("b_ready_idle", {31'b0, b_ready}, 32'd1);
                check("b_stall_idle", {31'b0, b_stall}, 32'd1);
            end
        end
        b_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
